// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap / mret sequencer. On an ecall/exception it writes mepc,
//   mcause and mstatus into the CSR file on three consecutive cycles, then
//   issues a one-cycle PC redirect to mtvec. On mret it rewrites mstatus and
//   redirects to mepc. While idle, it grants the pipeline's own CSR writes
//   straight through to the CSR file write port.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   trap_req        : trap request; trap_pc / trap_cause are captured with it
//   mret_req        : mret request (loses to trap_req when both are high)
//   pipe_csr_we     : pipeline CSR write valid (with pipe_csr_addr/wdata)
//   pipe_csr_ready  : pipeline CSR write granted this cycle
//   csr_mtvec/mepc/mstatus : current CSR values read from the CSR file
//   csr_we, csr_addr_w, csr_wdata : single CSR file write port
//   pc_redirect, redirect_pc      : one-cycle fetch redirect
//   busy            : a trap/mret sequence is in flight; the pipeline stalls
//
// Handshake: a pipeline CSR write transfers in exactly the cycle where
//   pipe_csr_we=1 and pipe_csr_ready=1. The grant is combinational, so the
//   write reaches the CSR file in that same cycle. When ready=0 the pipeline
//   keeps the request asserted and retries. trap_req / mret_req are level
//   requests sampled only while busy=0.
//
// Observability: the sequencer state is held in r_state (type state_t) for
//   binding checkers hierarchically.
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int data_width     = 32,
  parameter int csr_addr_width = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trap_req,
  input  logic [data_width-1:0]     trap_pc,
  input  logic [data_width-1:0]     trap_cause,
  input  logic                      mret_req,
  input  logic                      pipe_csr_we,
  input  logic [csr_addr_width-1:0] pipe_csr_addr,
  input  logic [data_width-1:0]     pipe_csr_wdata,
  output logic                      pipe_csr_ready,
  input  logic [data_width-1:0]     csr_mtvec,
  input  logic [data_width-1:0]     csr_mepc,
  input  logic [data_width-1:0]     csr_mstatus,
  output logic                      csr_we,
  output logic [csr_addr_width-1:0] csr_addr_w,
  output logic [data_width-1:0]     csr_wdata,
  output logic                      pc_redirect,
  output logic [data_width-1:0]     redirect_pc,
  output logic                      busy
);

  localparam logic [csr_addr_width-1:0] ADDR_MSTATUS = csr_addr_width'(12'h300);
  localparam logic [csr_addr_width-1:0] ADDR_MEPC    = csr_addr_width'(12'h341);
  localparam logic [csr_addr_width-1:0] ADDR_MCAUSE  = csr_addr_width'(12'h342);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    T_MEPC    = 3'd1,
    T_MCAUSE  = 3'd2,
    T_MSTATUS = 3'd3,
    T_REDIR   = 3'd4,
    M_MSTATUS = 3'd5,
    M_REDIR   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [data_width-1:0]   r_pc;
  logic [data_width-1:0]   r_cause;
  logic [data_width-1:0]   w_mstatus_trap;
  logic [data_width-1:0]   w_mstatus_mret;
  logic                    w_idle;

  assign w_idle = (r_state == IDLE);

  // ---------------------------------------------------------------------------
  // State and captured trap information
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && trap_req) begin
        r_pc    <= trap_pc;
        r_cause <= trap_cause;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // mstatus rewrites
  //   trap: MPIE <= MIE, MIE <= 0, MPP <= M
  //   mret: MIE <= MPIE, MPIE <= 1, MPP <= M
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mstatus_trap        = csr_mstatus;
    w_mstatus_trap[7]     = csr_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;

    w_mstatus_mret        = csr_mstatus;
    w_mstatus_mret[3]     = csr_mstatus[7];
    w_mstatus_mret[7]     = 1'b1;
    w_mstatus_mret[12:11] = 2'b11;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next         = r_state;
    csr_we         = 1'b0;
    csr_addr_w     = '0;
    csr_wdata      = '0;
    pc_redirect    = 1'b0;
    redirect_pc    = '0;
    busy           = !w_idle;
    // A request arriving in IDLE pre-empts the pipeline write that cycle.
    pipe_csr_ready = w_idle && !trap_req && !mret_req;

    unique case (r_state)
      IDLE: begin
        if (trap_req) begin
          w_next = T_MEPC;
        end else if (mret_req) begin
          w_next = M_MSTATUS;
        end else if (pipe_csr_we) begin
          csr_we     = 1'b1;
          csr_addr_w = pipe_csr_addr;
          csr_wdata  = pipe_csr_wdata;
        end
      end
      T_MEPC: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MEPC;
        csr_wdata  = {r_pc[data_width-1:2], 2'b00};
        w_next     = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MCAUSE;
        csr_wdata  = r_cause;
        w_next     = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MSTATUS;
        csr_wdata  = w_mstatus_trap;
        w_next     = T_REDIR;
      end
      T_REDIR: begin
        // Direct mode only: the mode bits of mtvec are dropped.
        pc_redirect = 1'b1;
        redirect_pc = {csr_mtvec[data_width-1:2], 2'b00};
        w_next      = IDLE;
      end
      M_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MSTATUS;
        csr_wdata  = w_mstatus_mret;
        w_next     = M_REDIR;
      end
      M_REDIR: begin
        pc_redirect = 1'b1;
        redirect_pc = csr_mepc;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Directed bench for trap_ctrl. Each scenario pushes the CSR writes and
//   redirects it expects onto exp_q; a monitor pops one entry for every cycle
//   in which the DUT writes a CSR or redirects the PC, and compares.
//   Entry layout: {is_redirect, addr[11:0], data[31:0]}.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int EW = 1 + AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          trap_req = 1'b0;
  logic [DW-1:0] trap_pc = '0;
  logic [DW-1:0] trap_cause = '0;
  logic          mret_req = 1'b0;
  logic          pipe_csr_we = 1'b0;
  logic [AW-1:0] pipe_csr_addr = '0;
  logic [DW-1:0] pipe_csr_wdata = '0;
  logic          pipe_csr_ready;
  logic [DW-1:0] csr_mtvec = '0;
  logic [DW-1:0] csr_mepc = '0;
  logic [DW-1:0] csr_mstatus = '0;
  logic          csr_we;
  logic [AW-1:0] csr_addr_w;
  logic [DW-1:0] csr_wdata;
  logic          pc_redirect;
  logic [DW-1:0] redirect_pc;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  trap_ctrl #(.data_width(DW), .csr_addr_width(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .mret_req       (mret_req),
    .pipe_csr_we    (pipe_csr_we),
    .pipe_csr_addr  (pipe_csr_addr),
    .pipe_csr_wdata (pipe_csr_wdata),
    .pipe_csr_ready (pipe_csr_ready),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .csr_mstatus    (csr_mstatus),
    .csr_we         (csr_we),
    .csr_addr_w     (csr_addr_w),
    .csr_wdata      (csr_wdata),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // ---------------------------------------------------------------------------
  // helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {1'b0, a, d};
  endfunction

  function automatic logic [EW-1:0] rd(input logic [DW-1:0] pc);
    return {1'b1, {AW{1'b0}}, pc};
  endfunction

  // Move to just after the next rising edge before driving inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles over n cycles, starting in the current cycle.
  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (i < n - 1) next_cycle();
    end
  endtask

  // Present a trap request for one cycle (DUT idle), checking that the
  // request blocks the pipeline port that cycle.
  task automatic issue_trap(input logic [DW-1:0] pc, input logic [DW-1:0] cause);
    next_cycle();
    trap_req   = 1'b1;
    trap_pc    = pc;
    trap_cause = cause;
    @(negedge clk);
    chk("trap_cycle_ready", 64'(pipe_csr_ready), 64'd0);
    next_cycle();
    trap_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // monitor: every write / redirect cycle is matched against exp_q
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] exp_item;
    if (csr_we === 1'b1 || pc_redirect === 1'b1) begin
      obs = pc_redirect ? {1'b1, {AW{1'b0}}, redirect_pc} : {1'b0, csr_addr_w, csr_wdata};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got 0x%0h expected none", obs);
      end else begin
        exp_item = exp_q.pop_front();
        if (obs !== exp_item || (csr_we && pc_redirect)) begin
          bad++;
          $display("FAIL event: got 0x%0h (we=%0b redir=%0b) expected 0x%0h",
                   obs, csr_we, pc_redirect, exp_item);
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",        64'(busy),           64'd0);
    chk("rst_csr_we",      64'(csr_we),         64'd0);
    chk("rst_pc_redirect", 64'(pc_redirect),    64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc),    64'd0);
    chk("rst_addr",        64'(csr_addr_w),     64'd0);
    chk("rst_wdata",       64'(csr_wdata),      64'd0);
    chk("rst_ready",       64'(pipe_csr_ready), 64'd1);
    next_cycle();
    rst = 1'b0;

    // ecall
    csr_mstatus = 32'h1808;
    csr_mtvec   = 32'h171;
    exp_q.push_back(wr(12'h341, 32'h104));
    exp_q.push_back(wr(12'h342, 32'd11));
    exp_q.push_back(wr(12'h300, 32'h1880));
    exp_q.push_back(rd(32'h170));
    issue_trap(32'h0000_0104, 32'd11);
    count_busy(6, n);
    chk("ecall_busy_cycles", 64'(n), 64'd4);
    chk("ecall_ready_after", 64'(pipe_csr_ready), 64'd1);

    // mret
    next_cycle();
    csr_mstatus = 32'h1880;
    csr_mepc    = 32'h0001_0000;
    mret_req    = 1'b1;
    exp_q.push_back(wr(12'h300, 32'h1888));
    exp_q.push_back(rd(32'h0001_0000));
    @(negedge clk);
    chk("mret_cycle_ready", 64'(pipe_csr_ready), 64'd0);
    next_cycle();
    mret_req = 1'b0;
    count_busy(4, n);
    chk("mret_busy_cycles", 64'(n), 64'd2);

    // simultaneous trap + mret: trap wins
    next_cycle();
    csr_mstatus = 32'h0008;
    csr_mtvec   = 32'h171;
    trap_req    = 1'b1;
    mret_req    = 1'b1;
    trap_pc     = 32'h200;
    trap_cause  = 32'd3;
    exp_q.push_back(wr(12'h341, 32'h200));
    exp_q.push_back(wr(12'h342, 32'd3));
    exp_q.push_back(wr(12'h300, 32'h1880));
    exp_q.push_back(rd(32'h170));
    next_cycle();
    trap_req = 1'b0;
    mret_req = 1'b0;
    count_busy(6, n);
    chk("both_busy_cycles", 64'(n), 64'd4);

    // pipeline write in IDLE
    next_cycle();
    pipe_csr_we    = 1'b1;
    pipe_csr_addr  = 12'h305;
    pipe_csr_wdata = 32'h200;
    exp_q.push_back(wr(12'h305, 32'h200));
    @(negedge clk);
    chk("pipe_ready", 64'(pipe_csr_ready), 64'd1);
    chk("pipe_busy",  64'(busy),           64'd0);
    next_cycle();
    pipe_csr_we = 1'b0;

    // same pipeline write colliding with a trap: refused, trap proceeds
    csr_mstatus    = 32'h1808;
    trap_req       = 1'b1;
    trap_pc        = 32'h0000_0107;
    trap_cause     = 32'd11;
    pipe_csr_we    = 1'b1;
    exp_q.push_back(wr(12'h341, 32'h104));
    exp_q.push_back(wr(12'h342, 32'd11));
    exp_q.push_back(wr(12'h300, 32'h1880));
    exp_q.push_back(rd(32'h170));
    @(negedge clk);
    chk("collide_ready", 64'(pipe_csr_ready), 64'd0);
    chk("collide_we",    64'(csr_we),         64'd0);
    next_cycle();
    trap_req    = 1'b0;
    pipe_csr_we = 1'b0;
    count_busy(6, n);
    chk("collide_busy_cycles", 64'(n), 64'd4);

    // reset while in T_MCAUSE: mcause write happens, nothing after
    exp_q.push_back(wr(12'h341, 32'h300));
    exp_q.push_back(wr(12'h342, 32'd5));
    issue_trap(32'h300, 32'd5);   // now in T_MEPC
    next_cycle();                 // now in T_MCAUSE
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_in_mcause", 64'(busy), 64'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_after",  64'(busy),        64'd0);
    chk("abort_we_after",    64'(csr_we),      64'd0);
    chk("abort_redir_after", 64'(pc_redirect), 64'd0);
    chk("abort_ready_after", 64'(pipe_csr_ready), 64'd1);
    repeat (4) next_cycle();

    // trap re-pulsed while busy: ignored
    csr_mstatus = 32'h1808;
    exp_q.push_back(wr(12'h341, 32'h400));
    exp_q.push_back(wr(12'h342, 32'd11));
    exp_q.push_back(wr(12'h300, 32'h1880));
    exp_q.push_back(rd(32'h170));
    issue_trap(32'h400, 32'd11);  // now in T_MEPC
    next_cycle();                 // now in T_MCAUSE
    trap_req   = 1'b1;
    trap_pc    = 32'h500;
    trap_cause = 32'd2;
    next_cycle();                 // now in T_MSTATUS
    trap_req = 1'b0;
    count_busy(6, n);
    chk("repulse_busy_cycles", 64'(n), 64'd2);
    repeat (3) next_cycle();

    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter data_width, default 32, CSR/PC data width.
REQ-002 SHALL have parameter csr_addr_width, default 12, CSR address width.
REQ-003 Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- trap_req  input  1  ecall/exception request from the pipeline.
- trap_pc  input  data_width  PC of the trapping instruction.
- trap_cause  input  data_width  mcause value (11 = ecall from M).
- mret_req  input  1  mret request from the pipeline.
- pipe_csr_we  input  1  pipeline CSR-instruction write request.
- pipe_csr_addr  input  csr_addr_width  pipeline CSR write address.
- pipe_csr_wdata  input  data_width  pipeline CSR write data.
- pipe_csr_ready  output  1  pipeline write granted this cycle.
- csr_mtvec  input  data_width  current mtvec.
- csr_mepc  input  data_width  current mepc.
- csr_mstatus  input  data_width  current mstatus.
- csr_we  output  1  CSR file write enable.
- csr_addr_w  output  csr_addr_width  CSR file write address.
- csr_wdata  output  data_width  CSR file write data.
- pc_redirect  output  1  one-cycle PC redirect pulse.
- redirect_pc  output  data_width  redirect target, valid when pc_redirect=1.
- busy  output  1  sequence in progress; pipeline stalls.

Function
REQ-004 SHALL implement FSM states IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, T_REDIR, M_MSTATUS, M_REDIR.
REQ-005 In IDLE with trap_req=1, SHALL capture trap_pc and trap_cause and go to T_MEPC next cycle.
REQ-006 In IDLE with mret_req=1 and trap_req=0, SHALL go to M_MSTATUS; trap_req SHALL win when both are high.
REQ-007 Trap sequence SHALL take exactly one cycle per state: T_MEPC -> T_MCAUSE -> T_MSTATUS -> T_REDIR -> IDLE.
REQ-008 T_MEPC SHALL drive csr_we=1, csr_addr_w=0x341, csr_wdata=captured pc with bits [1:0] forced to 0.
REQ-009 T_MCAUSE SHALL drive csr_we=1, csr_addr_w=0x342, csr_wdata=captured cause.
REQ-010 T_MSTATUS SHALL drive csr_we=1, csr_addr_w=0x300, csr_wdata=csr_mstatus with bit7(MPIE)=old bit3(MIE), bit3=0, bits[12:11]=2'b11, all other bits unchanged.
REQ-011 T_REDIR SHALL drive pc_redirect=1, redirect_pc=csr_mtvec with bits [1:0] cleared (direct mode only), csr_we=0.
REQ-012 Mret sequence SHALL be M_MSTATUS -> M_REDIR -> IDLE.
REQ-013 M_MSTATUS SHALL drive csr_we=1, csr_addr_w=0x300, csr_wdata=csr_mstatus with bit3=old bit7, bit7=1, bits[12:11]=2'b11, all other bits unchanged.
REQ-014 M_REDIR SHALL drive pc_redirect=1, redirect_pc=csr_mepc.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 trap_req and mret_req SHALL be ignored while busy=1; the requester holds them until it sees busy fall.
REQ-017 pipe_csr_ready SHALL be 1 only in IDLE with trap_req=0 and mret_req=0.
REQ-018 When pipe_csr_ready=1 and pipe_csr_we=1, SHALL pass pipe_csr_addr and pipe_csr_wdata to csr_addr_w/csr_wdata with csr_we=1 in the same cycle (combinational, zero latency).
REQ-019 In IDLE with no granted pipeline write, csr_we, csr_addr_w, csr_wdata, pc_redirect and redirect_pc SHALL all be 0.
REQ-020 A pipeline write arriving with a trap in the same cycle SHALL be refused (pipe_csr_ready=0) and not written; the trap proceeds.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE and clear the captured pc/cause to 0.
REQ-022 Reset SHALL take priority over all requests and abort any sequence in flight, so no later write or redirect is issued.
REQ-023 After reset: busy=0, csr_we=0, pc_redirect=0, redirect_pc=0, csr_addr_w=0, csr_wdata=0; pipe_csr_ready is 1 if no trap/mret is pending.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Ecall: trap_req, trap_pc=0x0000_0104, cause=11, mstatus=0x1808 -> writes 0x341=0x104, 0x342=11, 0x300=0x1880 on 3 consecutive cycles; then pc_redirect with redirect_pc=0x170 (mtvec=0x171); busy high 4 cycles.
- Mret: mret_req, mstatus=0x1880, mepc=0x0001_0000 -> 0x300=0x1888; next cycle pc_redirect=1, redirect_pc=0x10000.
- Simultaneous trap_req and mret_req -> trap sequence only; no mret write.
- Pipeline write 0x305<-0x200 in IDLE -> same-cycle csr_we=1, addr=0x305, data=0x200, ready=1. Same write with trap_req high -> ready=0, first write goes to 0x341.
- rst asserted in T_MCAUSE -> next cycle IDLE, busy=0; no 0x300 write, no redirect.
- trap_req re-pulsed while busy -> ignored; exactly one sequence runs.
